// File: rtl/magic_device_requester.sv
// MMIO read requester for the magic randomizer device port: decodes a 32 KiB window,
// performs one device read per request and returns tagged responses through a FWFT FIFO.
module magic_device_requester #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h6000_0000,
  parameter int                ID_W       = 4,
  parameter int                FIFO_DEPTH = 2,
  parameter int                TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_data,
  output logic [ID_W-1:0]   resp_id,
  output logic              resp_err,
  output logic [11:0]       read_select,
  output logic              read_ready,
  input  logic              read_valid,
  input  logic [63:0]       read_data,
  output logic [31:0]       rd_count,
  output logic [31:0]       err_count,
  output logic [1:0]        state_dbg
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ERR     = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] id_q;
  logic [TW-1:0]   tmo_cnt;

  logic [63:0]           data_mem [FIFO_DEPTH];
  logic [ID_W-1:0]       id_mem   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] err_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic        fire;
  logic        pop;
  logic        push;
  logic        push_err;
  logic [63:0] push_data;
  logic        tmo_hit;

  logic [ADDR_W-1:0] off;
  logic              dec_err;
  logic [11:0]       dec_sel;

  // Both req and resp channels transfer exactly on a clock edge where valid && ready;
  // valid never waits on ready, and ready here depends only on registered state.
  assign fire = req_valid && req_ready;
  assign pop  = resp_valid && resp_ready;

  // BASE_ADDR is 32 KiB aligned, so off[2:0] equals the byte offset inside a word.
  assign off     = req_addr - BASE_ADDR;
  assign dec_err = (req_addr < BASE_ADDR) || (off[ADDR_W-1:15] != '0) || (off[2:0] != 3'd0);
  assign dec_sel = off[14:3];

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push      = 1'b0;
    push_err  = 1'b0;
    push_data = '0;
    case (state)
      S_CAPTURE: begin
        push      = 1'b1;
        push_data = read_data;
      end
      S_ERR: begin
        push     = 1'b1;
        push_err = 1'b1;
      end
      S_ISSUE: begin
        if (!read_valid && tmo_hit) begin
          push     = 1'b1;
          push_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      read_ready  <= 1'b0;
      read_select <= '0;
      id_q        <= '0;
      tmo_cnt     <= '0;
      rd_count    <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            id_q    <= req_id;
            tmo_cnt <= '0;
            if (dec_err) begin
              state <= S_ERR;
            end else begin
              state       <= S_ISSUE;
              read_ready  <= 1'b1;
              read_select <= dec_sel;
            end
          end
        end
        S_ISSUE: begin
          if (read_valid) begin
            state      <= S_CAPTURE;
            read_ready <= 1'b0;
          end else if (tmo_hit) begin
            state      <= S_IDLE;
            read_ready <= 1'b0;
            err_count  <= err_count + 32'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          rd_count <= rd_count + 32'd1;
          state    <= S_IDLE;
        end
        S_ERR: begin
          err_count <= err_count + 32'd1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count decide what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      id_mem[wr_ptr]   <= id_q;
      err_mem[wr_ptr]  <= push_err;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign req_ready  = reset && (state == S_IDLE) && (count < CW'(FIFO_DEPTH));
  assign resp_valid = reset && (count != '0);
  assign resp_data  = resp_valid ? data_mem[rd_ptr] : '0;
  assign resp_id    = resp_valid ? id_mem[rd_ptr]   : '0;
  assign resp_err   = resp_valid ? err_mem[rd_ptr]  : 1'b0;
  assign state_dbg  = state;

endmodule

// File: tb/tb_magic_device_requester.sv
// Directed bench for magic_device_requester: decode, device read, timeout,
// FIFO back-pressure and mid-transaction reset.
module tb_magic_device_requester;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_id;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [3:0]  resp_id;
  logic        resp_err;
  logic [11:0] read_select;
  logic        read_ready;
  logic        read_valid;
  logic [63:0] read_data;
  logic [31:0] rd_count;
  logic [31:0] err_count;
  logic [1:0]  state_dbg;

  logic [63:0] dev_value;
  int          n_checks;
  int          n_fail;
  int          seen;

  localparam logic [63:0] D5 = 64'h0505_0505_AAAA_0005;
  localparam logic [63:0] D6 = 64'h0606_0606_BBBB_0006;
  localparam logic [63:0] D7 = 64'h0707_0707_CCCC_0007;

  magic_device_requester dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_id      (req_id),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_id     (resp_id),
    .resp_err    (resp_err),
    .read_select (read_select),
    .read_ready  (read_ready),
    .read_valid  (read_valid),
    .read_data   (read_data),
    .rd_count    (rd_count),
    .err_count   (err_count),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Device model: data changes on the falling edge of a handshake cycle.
  initial read_data = 64'd0;
  always @(negedge clock) begin
    if (read_ready && read_valid) read_data = dev_value;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [31:0] a, input logic [3:0] id);
    req_valid = v;
    req_addr  = a;
    req_id    = id;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    resp_ready = 1'b1;
    read_valid = 1'b0;
    dev_value  = 64'd0;
    drive_req(1'b0, 32'd0, 4'd0);

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_read_ready", 64'(read_ready), 64'd0);
    check("rst_read_select", 64'(read_select), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
    check("post_rst_state", 64'(state_dbg), 64'd0);

    // Good read: fire in C
    read_valid = 1'b1;
    dev_value  = 64'hCAFE_0000_1234_5678;
    drive_req(1'b1, 32'h6000_0018, 4'd3);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("rd_c1_read_ready", 64'(read_ready), 64'd1);
    check("rd_c1_read_select", 64'(read_select), 64'h003);
    check("rd_c1_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    check("rd_c2_read_ready", 64'(read_ready), 64'd0);
    check("rd_c2_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    check("rd_c3_resp_valid", 64'(resp_valid), 64'd1);
    check("rd_c3_resp_id", 64'(resp_id), 64'd3);
    check("rd_c3_resp_data", resp_data, 64'hCAFE_0000_1234_5678);
    check("rd_c3_resp_err", 64'(resp_err), 64'd0);
    check("rd_c3_rd_count", 64'(rd_count), 64'd1);
    tick();
    check("rd_popped", 64'(resp_valid), 64'd0);

    // Decode errors: out of window, then misaligned
    read_valid = 1'b0;
    drive_req(1'b1, 32'h6000_8000, 4'd1);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("e1_c1_req_ready", 64'(req_ready), 64'd0);
    check("e1_c1_read_ready", 64'(read_ready), 64'd0);
    check("e1_c1_resp_valid", 64'(resp_valid), 64'd0);
    tick();
    check("e1_c2_resp_valid", 64'(resp_valid), 64'd1);
    check("e1_c2_resp_id", 64'(resp_id), 64'd1);
    check("e1_c2_resp_err", 64'(resp_err), 64'd1);
    check("e1_c2_resp_data", resp_data, 64'd0);
    check("e1_c2_read_ready", 64'(read_ready), 64'd0);
    check("e1_c2_req_ready", 64'(req_ready), 64'd1);
    drive_req(1'b1, 32'h6000_0004, 4'd2);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("e2_c1_resp_valid", 64'(resp_valid), 64'd0);
    check("e2_c1_read_ready", 64'(read_ready), 64'd0);
    tick();
    check("e2_c2_resp_valid", 64'(resp_valid), 64'd1);
    check("e2_c2_resp_id", 64'(resp_id), 64'd2);
    check("e2_c2_resp_err", 64'(resp_err), 64'd1);
    check("e2_c2_resp_data", resp_data, 64'd0);
    check("e2_c2_err_count", 64'(err_count), 64'd2);
    check("e2_c2_rd_count", 64'(rd_count), 64'd1);
    tick();
    check("e2_popped", 64'(resp_valid), 64'd0);

    // Timeout: read_valid held low
    drive_req(1'b1, 32'h6000_0000, 4'd9);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("tmo_c1_read_ready", 64'(read_ready), 64'd1);
    check("tmo_c1_read_select", 64'(read_select), 64'h000);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check($sformatf("tmo_c%0d_read_ready", i), 64'(read_ready), 64'd1);
    end
    tick();
    check("tmo_c17_read_ready", 64'(read_ready), 64'd0);
    check("tmo_c17_resp_valid", 64'(resp_valid), 64'd1);
    check("tmo_c17_resp_id", 64'(resp_id), 64'd9);
    check("tmo_c17_resp_err", 64'(resp_err), 64'd1);
    check("tmo_c17_resp_data", resp_data, 64'd0);
    check("tmo_c17_err_count", 64'(err_count), 64'd3);
    check("tmo_c17_req_ready", 64'(req_ready), 64'd1);
    read_valid = 1'b1;
    dev_value  = 64'h1111_2222_3333_4444;
    drive_req(1'b1, 32'h6000_0008, 4'd4);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("after_tmo_read_ready", 64'(read_ready), 64'd1);
    check("after_tmo_read_select", 64'(read_select), 64'h001);
    check("after_tmo_popped", 64'(resp_valid), 64'd0);
    tick();
    tick();
    check("after_tmo_resp_id", 64'(resp_id), 64'd4);
    check("after_tmo_resp_data", resp_data, 64'h1111_2222_3333_4444);
    check("after_tmo_rd_count", 64'(rd_count), 64'd2);
    tick();

    // Back-pressure: resp_ready low, ids 5, 6, 7 back-to-back
    resp_ready = 1'b0;
    dev_value  = D5;
    drive_req(1'b1, 32'h6000_0100, 4'd5);
    check("bp_c0_req_ready", 64'(req_ready), 64'd1);
    tick();
    check("bp_c1_req_ready", 64'(req_ready), 64'd0);
    check("bp_c1_read_select", 64'(read_select), 64'h020);
    drive_req(1'b1, 32'h6000_0108, 4'd6);
    tick();
    check("bp_c2_req_ready", 64'(req_ready), 64'd0);
    dev_value = D6;
    tick();
    check("bp_c3_resp_id", 64'(resp_id), 64'd5);
    check("bp_c3_resp_data", resp_data, D5);
    check("bp_c3_req_ready", 64'(req_ready), 64'd1);
    tick();
    check("bp_c4_read_select", 64'(read_select), 64'h021);
    check("bp_c4_req_ready", 64'(req_ready), 64'd0);
    check("bp_c4_resp_id_held", 64'(resp_id), 64'd5);
    drive_req(1'b1, 32'h6000_0110, 4'd7);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_full%0d_req_ready", i), 64'(req_ready), 64'd0);
      check($sformatf("bp_full%0d_resp_id", i), 64'(resp_id), 64'd5);
      check($sformatf("bp_full%0d_resp_data", i), resp_data, D5);
      check($sformatf("bp_full%0d_state", i), 64'(state_dbg), 64'd0);
      tick();
    end
    resp_ready = 1'b1;
    dev_value  = D7;
    check("bp_drain0_resp_id", 64'(resp_id), 64'd5);
    tick();
    check("bp_drain1_resp_id", 64'(resp_id), 64'd6);
    check("bp_drain1_resp_data", resp_data, D6);
    check("bp_drain1_resp_err", 64'(resp_err), 64'd0);
    check("bp_drain1_req_ready", 64'(req_ready), 64'd1);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("bp_id7_resp_valid", 64'(resp_valid), 64'd0);
    check("bp_id7_read_ready", 64'(read_ready), 64'd1);
    check("bp_id7_read_select", 64'(read_select), 64'h022);
    tick();
    tick();
    check("bp_id7_resp_valid_c3", 64'(resp_valid), 64'd1);
    check("bp_id7_resp_id", 64'(resp_id), 64'd7);
    check("bp_id7_resp_data", resp_data, D7);
    check("bp_rd_count", 64'(rd_count), 64'd5);
    check("bp_err_count", 64'(err_count), 64'd3);
    tick();

    // Reset while in ISSUE
    read_valid = 1'b0;
    drive_req(1'b1, 32'h6000_0200, 4'hA);
    tick();
    drive_req(1'b0, 32'd0, 4'd0);
    check("mr_issue_state", 64'(state_dbg), 64'd1);
    check("mr_issue_read_ready", 64'(read_ready), 64'd1);
    reset = 1'b0;
    tick();
    check("mr_rst_state", 64'(state_dbg), 64'd0);
    check("mr_rst_read_ready", 64'(read_ready), 64'd0);
    check("mr_rst_read_select", 64'(read_select), 64'd0);
    check("mr_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mr_rst_req_ready", 64'(req_ready), 64'd0);
    check("mr_rst_rd_count", 64'(rd_count), 64'd0);
    check("mr_rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid || read_ready) seen++;
    end
    check("mr_no_response", 64'(seen), 64'd0);
    check("mr_req_ready", 64'(req_ready), 64'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
